// File: rtl/testbasic1_window_source.sv
// Window-sum producer stage: accumulates WINDOW signed samples from a_in and
// offers each sum on b_out using the sync/notify handshake on both sides.
module testbasic1_window_source #(
    parameter int WINDOW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       a_in,
    input  logic              a_in_sync,
    output logic              a_in_notify,
    output logic [31:0]       b_out,
    input  logic              b_out_sync,
    output logic              b_out_notify,
    output logic [CNT_W-1:0]  frame_count
);

    typedef enum logic {
        SECTION_READ,
        SECTION_WRITE
    } section_t;

    localparam logic [15:0] LAST_IDX = 16'(WINDOW - 1);

    section_t    section;
    logic [31:0] acc;
    logic [15:0] cnt;

    // Two's-complement addition is sign-agnostic, so plain vectors suffice;
    // sums wrap modulo 2^32 by construction.
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, exactly like the hardware does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            section      <= SECTION_READ;
            acc          <= '0;
            cnt          <= '0;
            b_out        <= '0;
            b_out_notify <= 1'b0;
            a_in_notify  <= 1'b1;
            frame_count  <= '0;
        end else begin
            case (section)
                SECTION_READ: begin
                    if (a_in_notify && a_in_sync) begin
                        if (cnt == LAST_IDX) begin
                            b_out        <= acc + a_in;
                            acc          <= '0;
                            cnt          <= '0;
                            a_in_notify  <= 1'b0;
                            b_out_notify <= 1'b1;
                            section      <= SECTION_WRITE;
                        end else begin
                            acc <= acc + a_in;
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                SECTION_WRITE: begin
                    // b_out is held and a_in ignored until downstream takes it
                    if (b_out_notify && b_out_sync) begin
                        b_out_notify <= 1'b0;
                        a_in_notify  <= 1'b1;
                        frame_count  <= frame_count + 1'b1;
                        section      <= SECTION_READ;
                    end
                end
                default: section <= SECTION_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_testbasic1_window_source.sv
// Bench for testbasic1_window_source: a queue-based window model checked every
// cycle on two instances (WINDOW=4/CNT_W=16 and WINDOW=1/CNT_W=2), plus literals.
module tb_testbasic1_window_source;

    localparam int WIN_A = 4;
    localparam int WIN_B = 1;

    logic        clk;
    logic        rst;

    logic [31:0] a_a, b_out_a;
    logic        sa, an_a, bsa, bn_a;
    logic [15:0] frm_a;

    logic [31:0] a_b, b_out_b;
    logic        sb, an_b, bsb, bn_b;
    logic [1:0]  frm_b;

    int errors = 0;
    int checks = 0;

    testbasic1_window_source #(.WINDOW(WIN_A), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .a_in(a_a), .a_in_sync(sa), .a_in_notify(an_a),
        .b_out(b_out_a), .b_out_sync(bsa), .b_out_notify(bn_a),
        .frame_count(frm_a)
    );

    testbasic1_window_source #(.WINDOW(WIN_B), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .a_in(a_b), .a_in_sync(sb), .a_in_notify(an_b),
        .b_out(b_out_b), .b_out_sync(bsb), .b_out_notify(bn_b),
        .frame_count(frm_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sum_q(input logic [31:0] q[$]);
        logic [31:0] s = '0;
        foreach (q[i]) s = s + q[i];
        return s;
    endfunction

    // Model: a window is the list of accepted samples; when it reaches WINDOW
    // entries their sum is offered until downstream takes it.
    logic [31:0] q_a[$];
    logic        m_off_a;
    logic [31:0] m_val_a;
    logic [15:0] m_frm_a;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_a.delete();
            m_off_a <= 1'b0;
            m_val_a <= '0;
            m_frm_a <= '0;
        end else if (!m_off_a) begin
            if (sa) begin
                if (q_a.size() + 1 == WIN_A) begin
                    m_val_a <= sum_q(q_a) + a_a;
                    m_off_a <= 1'b1;
                    q_a.delete();
                end else begin
                    q_a.push_back(a_a);
                end
            end
        end else if (bsa) begin
            m_off_a <= 1'b0;
            m_frm_a <= m_frm_a + 16'd1;
        end
    end

    logic [31:0] q_b[$];
    logic        m_off_b;
    logic [31:0] m_val_b;
    logic [1:0]  m_frm_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_b.delete();
            m_off_b <= 1'b0;
            m_val_b <= '0;
            m_frm_b <= '0;
        end else if (!m_off_b) begin
            if (sb) begin
                if (q_b.size() + 1 == WIN_B) begin
                    m_val_b <= sum_q(q_b) + a_b;
                    m_off_b <= 1'b1;
                    q_b.delete();
                end else begin
                    q_b.push_back(a_b);
                end
            end
        end else if (bsb) begin
            m_off_b <= 1'b0;
            m_frm_b <= m_frm_b + 2'd1;
        end
    end

    always @(negedge clk) begin
        check("a.b_out",        64'(b_out_a), 64'(m_val_a));
        check("a.b_out_notify", 64'(bn_a),    64'(m_off_a));
        check("a.a_in_notify",  64'(an_a),    64'(!m_off_a));
        check("a.frame_count",  64'(frm_a),   64'(m_frm_a));
        check("b.b_out",        64'(b_out_b), 64'(m_val_b));
        check("b.b_out_notify", 64'(bn_b),    64'(m_off_b));
        check("b.a_in_notify",  64'(an_b),    64'(!m_off_b));
        check("b.frame_count",  64'(frm_b),   64'(m_frm_b));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] t1_vals[4] = '{32'd1, 32'd2, 32'd3, 32'd4};
        logic [31:0] t3_vals[4] = '{32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFB, 32'd5};
        logic [31:0] t4_vals[4] = '{32'd7, 32'hFFFF_FFF9, 32'd100, 32'd1};
        logic [31:0] t6_vals[5] = '{32'd5, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'd42, 32'hFFFF_FFFF};
        logic [1:0]  t6_frm[5]  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b0;
        a_a = '0; sa = 1'b0; bsa = 1'b0;
        a_b = '0; sb = 1'b0; bsb = 1'b1;
        step();
        check("reset.b_out",        64'(b_out_a), 64'd0);
        check("reset.b_out_notify", 64'(bn_a),    64'd0);
        check("reset.a_in_notify",  64'(an_a),    64'd1);
        check("reset.frame_count",  64'(frm_a),   64'd0);
        step();
        rst = 1'b1;
        step();

        // 1: basic window 1+2+3+4
        bsa = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_a = t1_vals[i]; sa = 1'b1;
            step();
        end
        check("t1.sum",         64'(b_out_a), 64'd10);
        check("t1.notify_high", 64'(bn_a),    64'd1);
        check("t1.a_ready_low", 64'(an_a),    64'd0);
        sa = 1'b0;
        step();
        check("t1.notify_one_cycle", 64'(bn_a),  64'd0);
        check("t1.a_ready_back",     64'(an_a),  64'd1);
        check("t1.frame_count",      64'(frm_a), 64'd1);

        // 2: backpressure holds the offer
        bsa = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_a = t1_vals[i]; sa = 1'b1;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            a_a = 32'(i * 11 + 3); sa = i[0];
            step();
            check("t2.held_sum",    64'(b_out_a), 64'd10);
            check("t2.held_notify", 64'(bn_a),    64'd1);
            check("t2.held_a_low",  64'(an_a),    64'd0);
        end
        sa = 1'b0; bsa = 1'b1;
        step();
        check("t2.frame_count", 64'(frm_a), 64'd2);
        check("t2.released",    64'(bn_a),  64'd0);

        // 3: signed wrap
        for (int i = 0; i < 4; i++) begin
            a_a = t3_vals[i]; sa = 1'b1;
            step();
        end
        check("t3.wrap_sum", 64'(b_out_a), 64'h8000_0000);
        sa = 1'b0;
        step();
        check("t3.frame_count", 64'(frm_a), 64'd3);

        // 4: sparse input, garbage on idle cycles
        for (int i = 0; i < 4; i++) begin
            a_a = t4_vals[i]; sa = 1'b1;
            step();
            sa = 1'b0;
            a_a = 32'hDEAD_0000 + 32'(i);
            step();
            step();
        end
        check("t4.sparse_sum", 64'(b_out_a), 64'd101);
        check("t4.frame_count", 64'(frm_a),  64'd4);

        // 5: async reset mid-window discards partial sum
        for (int i = 0; i < 2; i++) begin
            a_a = 32'd3; sa = 1'b1;
            step();
        end
        sa = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t5.rst_b_out",  64'(b_out_a), 64'd0);
        check("t5.rst_frame",  64'(frm_a),   64'd0);
        check("t5.rst_a_rdy",  64'(an_a),    64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            a_a = 32'd1; sa = 1'b1;
            step();
        end
        check("t5.sum_after_reset", 64'(b_out_a), 64'd4);
        sa = 1'b0;
        step();
        check("t5.frame_count", 64'(frm_a), 64'd1);

        // 6: WINDOW=1 echoes each sample, 2-bit frame counter wraps
        bsb = 1'b1;
        sb  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_b = t6_vals[i];
            step();
            check("t6.echo",   64'(b_out_b), 64'(t6_vals[i]));
            check("t6.notify", 64'(bn_b),    64'd1);
            step();
            check("t6.frame_count", 64'(frm_b), 64'(t6_frm[i]));
        end
        sb = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
